// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, access size encodings
// and the default bus timeout.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    localparam logic [1:0] LSU_SIZE_BYTE    = 2'b00;
    localparam logic [1:0] LSU_SIZE_HALF    = 2'b01;
    localparam logic [1:0] LSU_SIZE_WORD    = 2'b10;
    localparam logic [1:0] LSU_SIZE_ILLEGAL = 2'b11;

    localparam int LSU_TIMEOUT_DEFAULT = 255;

    // Accesses that must fault locally without touching the bus.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == LSU_SIZE_ILLEGAL)
            || ((size == LSU_SIZE_HALF) && addr_lo[0])
            || ((size == LSU_SIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request side (from the control FSM) and memory bus side of the LSU, bundled.
// The master modport is the LSU's view; slave is the view of its environment.
interface lsu_if;

    logic        lsu_reqValid;
    logic        lsu_wen;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    logic        lsu_err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport master (
        input  lsu_reqValid, lsu_wen, lsu_addr, lsu_wdata, lsu_size, lsu_unsigned,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
        output lsu_respValid, lsu_rdata, lsu_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        output lsu_reqValid, lsu_wen, lsu_addr, lsu_wdata, lsu_size, lsu_unsigned,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err,
        input  lsu_respValid, lsu_rdata, lsu_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic: store data replication, write strobes, and load
// right-shift with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_rep,
    output logic [3:0]  wstrb,
    output logic [31:0] rdata_ext
);

    logic [31:0] rdata_sh;
    logic        sign;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        rdata_sh  = rdata >> {addr_lo, 3'b000};
        wdata_rep = wdata;
        wstrb     = 4'b1111;
        rdata_ext = rdata_sh;
        sign      = 1'b0;
        case (size)
            LSU_SIZE_BYTE: begin
                sign      = ~is_unsigned & rdata_sh[7];
                wdata_rep = {4{wdata[7:0]}};
                wstrb     = 4'b0001 << addr_lo;
                rdata_ext = {{24{sign}}, rdata_sh[7:0]};
            end
            LSU_SIZE_HALF: begin
                sign      = ~is_unsigned & rdata_sh[15];
                wdata_rep = {2{wdata[15:0]}};
                wstrb     = 4'b0011 << addr_lo;
                rdata_ext = {{16{sign}}, rdata_sh[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one access at a time, IDLE -> REQ -> WAIT -> RESP, with a
// bus-wait timeout and local faulting of misaligned or illegal-size accesses.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
    input  logic  clock,
    input  logic  reset,
    lsu_if.master bus
);

    lsu_state_e  state;
    logic        wen_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  addr_lo_q;
    logic [16:0] cnt_q;
    logic [16:0] spent;
    logic        timed_out;

    logic        idle;
    logic [1:0]  al_size;
    logic [1:0]  al_addr;
    logic        al_uns;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_ext;
    logic [3:0]  wstrb;

    // Lanes are computed from live inputs at accept time, from the latched copy afterwards.
    assign idle    = (state == ST_IDLE);
    assign al_size = idle ? bus.lsu_size         : size_q;
    assign al_addr = idle ? bus.lsu_addr[1:0]    : addr_lo_q;
    assign al_uns  = idle ? bus.lsu_unsigned     : uns_q;

    assign spent     = cnt_q + 17'd1;
    assign timed_out = (spent >= 17'(TIMEOUT));

    lsu_align u_align (
        .size       (al_size),
        .addr_lo    (al_addr),
        .is_unsigned(al_uns),
        .wdata      (bus.lsu_wdata),
        .rdata      (bus.mem_rdata),
        .wdata_rep  (wdata_rep),
        .wstrb      (wstrb),
        .rdata_ext  (rdata_ext)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: non-blocking assignments make every update read pre-edge values.
            state             <= ST_IDLE;
            cnt_q             <= '0;
            wen_q             <= 1'b0;
            uns_q             <= 1'b0;
            size_q            <= LSU_SIZE_BYTE;
            addr_lo_q         <= 2'b00;
            bus.lsu_respValid <= 1'b0;
            bus.lsu_rdata     <= '0;
            bus.lsu_err       <= 1'b0;
            bus.mem_req       <= 1'b0;
            bus.mem_we        <= 1'b0;
            bus.mem_addr      <= '0;
            bus.mem_wdata     <= '0;
            bus.mem_wstrb     <= '0;
        end else begin
            bus.lsu_respValid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.lsu_reqValid) begin
                        wen_q     <= bus.lsu_wen;
                        uns_q     <= bus.lsu_unsigned;
                        size_q    <= bus.lsu_size;
                        addr_lo_q <= bus.lsu_addr[1:0];
                        cnt_q     <= '0;
                        if (lsu_misaligned(bus.lsu_size, bus.lsu_addr[1:0])) begin
                            state             <= ST_RESP;
                            bus.lsu_respValid <= 1'b1;
                            bus.lsu_err       <= 1'b1;
                            bus.lsu_rdata     <= '0;
                        end else begin
                            state         <= ST_REQ;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.lsu_wen;
                            bus.mem_addr  <= {bus.lsu_addr[31:2], 2'b00};
                            bus.mem_wdata <= bus.lsu_wen ? wdata_rep : 32'h0;
                            bus.mem_wstrb <= bus.lsu_wen ? wstrb : 4'b0000;
                        end
                    end
                end
                ST_REQ: begin
                    cnt_q <= spent;
                    if (bus.mem_gnt || timed_out) begin
                        bus.mem_req   <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= '0;
                        bus.mem_wdata <= '0;
                        bus.mem_wstrb <= '0;
                    end
                    // A grant wins over an expiring timeout; any rvalid here is dropped.
                    if (bus.mem_gnt) begin
                        state <= ST_WAIT;
                    end else if (timed_out) begin
                        state             <= ST_RESP;
                        bus.lsu_respValid <= 1'b1;
                        bus.lsu_err       <= 1'b1;
                        bus.lsu_rdata     <= '0;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= spent;
                    if (bus.mem_rvalid) begin
                        state             <= ST_RESP;
                        bus.lsu_respValid <= 1'b1;
                        bus.lsu_err       <= bus.mem_err;
                        bus.lsu_rdata     <= (wen_q || bus.mem_err) ? 32'h0 : rdata_ext;
                    end else if (timed_out) begin
                        state             <= ST_RESP;
                        bus.lsu_respValid <= 1'b1;
                        bus.lsu_err       <= 1'b1;
                        bus.lsu_rdata     <= '0;
                    end
                end
                ST_RESP: begin
                    state         <= ST_IDLE;
                    bus.lsu_err   <= 1'b0;
                    bus.lsu_rdata <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: one instance with the default timeout and one with
// TIMEOUT=4, driven one step at a time and checked #1 after each rising edge.
module tb_lsu;
    import lsu_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    lsu_if bus ();
    lsu_if tbus ();

    lsu u_dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    lsu #(.TIMEOUT(4)) u_dut_to (
        .clock(clock),
        .reset(reset),
        .bus  (tbus.master)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns);
        bus.lsu_reqValid = 1'b1;
        bus.lsu_wen      = wen;
        bus.lsu_addr     = addr;
        bus.lsu_wdata    = wdata;
        bus.lsu_size     = size;
        bus.lsu_unsigned = uns;
    endtask

    // Accept, grant on the first REQ cycle, respond on the first WAIT cycle; ends in RESP.
    task automatic xfer(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns,
                        input logic [31:0] rdata, input logic err);
        issue(wen, addr, wdata, size, uns);
        tick();
        bus.lsu_reqValid = 1'b0;
        bus.mem_gnt      = 1'b1;
        tick();
        bus.mem_gnt      = 1'b0;
        bus.mem_rvalid   = 1'b1;
        bus.mem_rdata    = rdata;
        bus.mem_err      = err;
        tick();
        bus.mem_rvalid   = 1'b0;
        bus.mem_err      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int resp_cnt;
        logic [31:0] resp_data;

        reset = 1'b0;
        bus.lsu_reqValid = 1'b0; bus.lsu_wen = 1'b0; bus.lsu_addr = '0; bus.lsu_wdata = '0;
        bus.lsu_size = LSU_SIZE_BYTE; bus.lsu_unsigned = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_err = 1'b0;
        tbus.lsu_reqValid = 1'b0; tbus.lsu_wen = 1'b0; tbus.lsu_addr = '0; tbus.lsu_wdata = '0;
        tbus.lsu_size = LSU_SIZE_BYTE; tbus.lsu_unsigned = 1'b0;
        tbus.mem_gnt = 1'b0; tbus.mem_rvalid = 1'b0; tbus.mem_rdata = '0; tbus.mem_err = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst.respValid", bus.lsu_respValid, 1'b0);
        check("rst.mem_req", bus.mem_req, 1'b0);
        check("rst.mem_wstrb", bus.mem_wstrb, 4'h0);
        check("rst.rdata", bus.lsu_rdata, 32'h0);
        check("rst.err", bus.lsu_err, 1'b0);
        check("rst.to_mem_req", tbus.mem_req, 1'b0);
        reset = 1'b1;
        tick();

        // Signed byte load from lane 3, zero-wait bus
        issue(1'b0, 32'h0000_1003, 32'h0, LSU_SIZE_BYTE, 1'b0);
        tick();
        bus.lsu_reqValid = 1'b0;
        check("ld_b.mem_req", bus.mem_req, 1'b1);
        check("ld_b.mem_addr", bus.mem_addr, 32'h0000_1000);
        check("ld_b.mem_wstrb", bus.mem_wstrb, 4'h0);
        check("ld_b.mem_we", bus.mem_we, 1'b0);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        check("ld_b.req_drop", bus.mem_req, 1'b0);
        check("ld_b.no_early_resp", bus.lsu_respValid, 1'b0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h80FF_FFFF;
        tick();
        bus.mem_rvalid = 1'b0;
        check("ld_b.respValid", bus.lsu_respValid, 1'b1);
        check("ld_b.rdata", bus.lsu_rdata, 32'hFFFF_FF80);
        check("ld_b.err", bus.lsu_err, 1'b0);
        tick();
        check("ld_b.pulse_end", bus.lsu_respValid, 1'b0);

        // Half store to upper lanes, grant delayed by one cycle
        issue(1'b1, 32'h0000_2002, 32'h1234_ABCD, LSU_SIZE_HALF, 1'b0);
        tick();
        bus.lsu_reqValid = 1'b0;
        check("st_h.mem_wdata", bus.mem_wdata, 32'hABCD_ABCD);
        check("st_h.mem_wstrb", bus.mem_wstrb, 4'b1100);
        check("st_h.mem_addr", bus.mem_addr, 32'h0000_2000);
        check("st_h.mem_we", bus.mem_we, 1'b1);
        tick();
        check("st_h.req_held", bus.mem_req, 1'b1);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        tick();
        bus.mem_rvalid = 1'b0;
        check("st_h.respValid", bus.lsu_respValid, 1'b1);
        check("st_h.rdata_zero", bus.lsu_rdata, 32'h0);
        tick();

        // Byte store to lane 1
        issue(1'b1, 32'h0000_2001, 32'h0000_00AB, LSU_SIZE_BYTE, 1'b0);
        tick();
        bus.lsu_reqValid = 1'b0;
        check("st_b.mem_wdata", bus.mem_wdata, 32'hABAB_ABAB);
        check("st_b.mem_wstrb", bus.mem_wstrb, 4'b0010);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        tick();

        // Misaligned word load faults one cycle after accept
        issue(1'b0, 32'h0000_1001, 32'h0, LSU_SIZE_WORD, 1'b0);
        tick();
        bus.lsu_reqValid = 1'b0;
        check("mis_w.respValid", bus.lsu_respValid, 1'b1);
        check("mis_w.err", bus.lsu_err, 1'b1);
        check("mis_w.rdata", bus.lsu_rdata, 32'h0);
        check("mis_w.no_req", bus.mem_req, 1'b0);
        tick();
        check("mis_w.pulse_end", bus.lsu_respValid, 1'b0);

        // Illegal size faults even when aligned
        issue(1'b0, 32'h0000_0000, 32'h0, LSU_SIZE_ILLEGAL, 1'b0);
        tick();
        bus.lsu_reqValid = 1'b0;
        check("ill.err", bus.lsu_err, 1'b1);
        check("ill.no_req", bus.mem_req, 1'b0);
        tick();

        // gnt and rvalid together in REQ: only the grant counts
        issue(1'b0, 32'h0001_0002, 32'h0, LSU_SIZE_HALF, 1'b1);
        tick();
        bus.lsu_reqValid = 1'b0;
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        tick();
        bus.mem_gnt = 1'b0;
        check("gnt_rv.no_resp", bus.lsu_respValid, 1'b0);
        bus.mem_rdata = 32'h8001_1234;
        tick();
        bus.mem_rvalid = 1'b0;
        check("ld_hu.respValid", bus.lsu_respValid, 1'b1);
        check("ld_hu.rdata", bus.lsu_rdata, 32'h0000_8001);
        tick();

        // Signed half from lane 0
        xfer(1'b0, 32'h0000_6000, 32'h0, LSU_SIZE_HALF, 1'b0, 32'h1234_9ABC, 1'b0);
        check("ld_hs.rdata", bus.lsu_rdata, 32'hFFFF_9ABC);
        tick();

        // Bus error forces zero data
        xfer(1'b0, 32'h0000_6000, 32'h0, LSU_SIZE_HALF, 1'b0, 32'h0000_FFFF, 1'b1);
        check("bus_err.err", bus.lsu_err, 1'b1);
        check("bus_err.rdata", bus.lsu_rdata, 32'h0);
        tick();

        // Reset in WAIT, then a late rvalid
        issue(1'b0, 32'h0000_3000, 32'h0, LSU_SIZE_WORD, 1'b0);
        tick();
        bus.lsu_reqValid = 1'b0;
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        reset = 1'b0;
        tick();
        check("rst_mid.respValid", bus.lsu_respValid, 1'b0);
        check("rst_mid.mem_req", bus.mem_req, 1'b0);
        check("rst_mid.mem_wdata", bus.mem_wdata, 32'h0);
        reset = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1111_1111;
        tick();
        bus.mem_rvalid = 1'b0;
        check("rst_mid.late_rvalid", bus.lsu_respValid, 1'b0);
        tick();
        check("rst_mid.still_quiet", bus.lsu_respValid, 1'b0);
        xfer(1'b0, 32'h0000_3004, 32'h0, LSU_SIZE_WORD, 1'b0, 32'h55AA_1234, 1'b0);
        check("rst_next.respValid", bus.lsu_respValid, 1'b1);
        check("rst_next.rdata", bus.lsu_rdata, 32'h55AA_1234);
        tick();

        // reqValid held for 10 cycles: grant after 4 REQ waits, rvalid after 2 WAIT waits
        hs = 0;
        resp_cnt = 0;
        resp_data = '0;
        issue(1'b0, 32'h0000_4000, 32'h0, LSU_SIZE_WORD, 1'b0);
        for (int i = 0; i < 13; i++) begin
            bus.lsu_reqValid = (i < 10);
            bus.mem_gnt      = (i == 5);
            bus.mem_rvalid   = (i == 8);
            bus.mem_rdata    = 32'h0BAD_F00D;
            if (bus.mem_req && bus.mem_gnt) hs++;
            tick();
            if (bus.lsu_respValid) begin
                resp_cnt++;
                resp_data = bus.lsu_rdata;
            end
        end
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        check("hold.handshakes", hs, 1);
        check("hold.responses", resp_cnt, 1);
        check("hold.rdata", resp_data, 32'h0BAD_F00D);

        // Timeout instance: granted, never answered
        tbus.lsu_reqValid = 1'b1;
        tbus.lsu_wen      = 1'b0;
        tbus.lsu_addr     = 32'h0000_0100;
        tbus.lsu_size     = LSU_SIZE_WORD;
        tbus.mem_gnt      = 1'b1;
        tick();
        tbus.lsu_reqValid = 1'b0;
        check("to.mem_req", tbus.mem_req, 1'b1);
        tick();
        check("to.req_drop", tbus.mem_req, 1'b0);
        tick();
        tick();
        check("to.not_yet", tbus.lsu_respValid, 1'b0);
        tick();
        check("to.respValid", tbus.lsu_respValid, 1'b1);
        check("to.err", tbus.lsu_err, 1'b1);
        check("to.rdata", tbus.lsu_rdata, 32'h0);
        check("to.mem_req_low", tbus.mem_req, 1'b0);
        tbus.mem_gnt = 1'b0;
        tick();
        check("to.pulse_end", tbus.lsu_respValid, 1'b0);
        tbus.mem_rvalid = 1'b1;
        tbus.mem_rdata  = 32'h0000_ABCD;
        tick();
        tbus.mem_rvalid = 1'b0;
        check("to.late_rvalid", tbus.lsu_respValid, 1'b0);
        tick();
        check("to.late_rvalid2", tbus.lsu_respValid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: bus-wait cycles before abort; legal range 1..65535.
REQ-002 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port lsu_reqValid  input  1  access request from the control FSM; may stay high while busy.
REQ-005 SHALL have port lsu_wen  input  1  1 = store, 0 = load.
REQ-006 SHALL have port lsu_addr  input  32  byte address.
REQ-007 SHALL have port lsu_wdata  input  32  store data, right-aligned.
REQ-008 SHALL have port lsu_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port lsu_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port lsu_respValid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port lsu_rdata  output  32  extended load data, valid with lsu_respValid.
REQ-012 SHALL have port lsu_err  output  1  access faulted, valid with lsu_respValid.
REQ-013 SHALL have port mem_req  output  1  bus request, held until mem_gnt.
REQ-014 SHALL have port mem_we  output  1  bus write enable.
REQ-015 SHALL have port mem_addr  output  32  word-aligned address {lsu_addr[31:2],2'b00}.
REQ-016 SHALL have port mem_wdata  output  32  lane-replicated store data.
REQ-017 SHALL have port mem_wstrb  output  4  byte strobes; 0 for loads.
REQ-018 SHALL have port mem_gnt  input  1  request accepted this cycle.
REQ-019 SHALL have port mem_rvalid  input  1  response (read data or write ack) valid.
REQ-020 SHALL have port mem_rdata  input  32  read word.
REQ-021 SHALL have port mem_err  input  1  bus error, valid with mem_rvalid.

Function
REQ-022 SHALL implement FSM IDLE -> REQ -> WAIT -> RESP -> IDLE.
REQ-023 SHALL accept a request only in IDLE with lsu_reqValid=1, latching wen, addr, wdata, size and unsigned at that edge; inputs are ignored in all other states.
REQ-024 SHALL, on a misaligned access (half with addr[0]=1, word with addr[1:0]!=0) or size=11, go IDLE->RESP without a bus request, with lsu_err=1 and lsu_rdata=0.
REQ-025 SHALL hold mem_req=1 in REQ; mem_gnt=1 moves the FSM to WAIT and drops mem_req on the next cycle.
REQ-026 SHALL move from WAIT to RESP on mem_rvalid=1, capturing mem_rdata and mem_err.
REQ-027 SHALL assert lsu_respValid for exactly one cycle (RESP) and return to IDLE on the next edge; minimum accept-to-respValid latency is 3 cycles (gnt on the first REQ cycle, rvalid on the first WAIT cycle).
REQ-028 SHALL, for stores: byte -> mem_wdata={4{wdata[7:0]}}, mem_wstrb=4'b0001<<addr[1:0]; half -> {2{wdata[15:0]}}, 4'b0011<<addr[1:0]; word -> wdata, 4'b1111.
REQ-029 SHALL, for loads, shift mem_rdata right by 8*addr[1:0], then sign- or zero-extend from bit 7 (byte) or bit 15 (half) according to lsu_unsigned.
REQ-030 SHALL drive lsu_rdata=0 for stores and for any lsu_err=1 response.
REQ-031 SHALL count cycles spent in REQ+WAIT; reaching TIMEOUT moves the FSM to RESP with lsu_err=1 and mem_req=0.
REQ-032 SHALL ignore mem_rvalid and mem_gnt outside REQ/WAIT, including a late response after a timeout or a reset.
REQ-033 SHALL, when mem_gnt and mem_rvalid are both high in REQ, complete via REQ->WAIT only; the rvalid in that cycle is ignored.

Reset
REQ-034 SHALL, on the edge where reset=0, force IDLE, clear the timeout counter, and drive every output to 0 from that edge on, including mid-operation.
REQ-035 SHALL issue no lsu_respValid for an access aborted by reset.

Structure
REQ-036 SHALL place the state enum, LSU_SIZE_* encodings and the default TIMEOUT in the shared defs package used by the control FSM.
REQ-037 SHALL factor lane shift, strobe generation and extension into combinational sub-module lsu_align.

Verification
REQ-038 SHALL cover: load byte, addr=0x1003, unsigned=0, mem_rdata=0x80FF_FFFF, gnt and rvalid after 0 waits -> lsu_rdata=0xFFFF_FF80, respValid 3 cycles after accept.
REQ-039 SHALL cover: store half, addr=0x2002, wdata=0x1234_ABCD -> mem_wdata=0xABCD_ABCD, mem_wstrb=4'b1100, mem_addr=0x2000, mem_we=1.
REQ-040 SHALL cover: load word, addr=0x1001 -> no mem_req, lsu_err=1, lsu_rdata=0, respValid 1 cycle after accept.
REQ-041 SHALL cover: TIMEOUT=4, mem_gnt=1, mem_rvalid never high -> lsu_err=1 at RESP; a late rvalid in IDLE produces no pulse.
REQ-042 SHALL cover: reset=0 in WAIT, then rvalid=1 -> outputs 0, no respValid; the next request completes normally.
REQ-043 SHALL cover: lsu_reqValid held high for 10 cycles with rvalid after 2 waits -> exactly one bus request and one respValid.
